// File: rtl/bus_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_slave_if
//  Description : Responder end of the shared bus. Accepts one selected access
//                (cs_/as_), inserts WAIT_CYCLES wait states, hands it to a
//                req/ack peripheral port and returns a single-cycle rdy_ with
//                read data. Optional REQ timeout when BUS_SLAVE_TIMEOUT_EN is
//                defined; without it REQ waits for dev_ack indefinitely.
//  Revision    : 1.0  initial release
// ============================================================================
module bus_slave_if #(
    parameter int ADDR_W         = 8,
    parameter int WAIT_CYCLES    = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_cs_,
    input  logic              s_as_,
    input  logic              s_rw,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [31:0]       s_wr_data,
    output logic [31:0]       s_rd_data,
    output logic              s_rdy_,
    output logic              dev_req,
    output logic              dev_we,
    output logic [ADDR_W-1:0] dev_addr,
    output logic [31:0]       dev_wdata,
    input  logic              dev_ack,
    input  logic [31:0]       dev_rdata,
    output logic              timeout_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_REQ  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    // WAIT is entered with WAIT_CYCLES-1 so that it lasts exactly WAIT_CYCLES cycles
    localparam logic [7:0] C_WAIT_LOAD = 8'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);
    localparam logic [31:0] C_TMO_DATA = 32'hDEAD_BEEF;

    // Reject parameter values the 8-bit counters cannot represent
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 255 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_param
        $error("bus_slave_if: WAIT_CYCLES or TIMEOUT_CYCLES out of range");
    end

    logic [1:0]        state_q, state_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic              dev_req_q, dev_req_d;
    logic              dev_we_q, dev_we_d;
    logic [ADDR_W-1:0] dev_addr_q, dev_addr_d;
    logic [31:0]       dev_wdata_q, dev_wdata_d;
    logic              rdy_q, rdy_d;
    logic [31:0]       rd_data_q, rd_data_d;
    logic              w_accept;
    logic              w_timeout;

    assign w_accept = ~s_cs_ & ~s_as_;

`ifdef BUS_SLAVE_TIMEOUT_EN
    localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       tmo_err_q, tmo_err_d;

    // Expiry only when the last allowed REQ cycle passes without dev_ack (ack wins)
    assign w_timeout = (state_q == S_REQ) && !dev_ack && (tmo_cnt_q == C_TMO_LAST);

    // Count REQ cycles; cleared whenever REQ is left so each access starts at 0
    always_comb begin
        tmo_cnt_d = 8'd0;
        if (state_q == S_REQ && state_d == S_REQ) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
        tmo_err_d = tmo_err_q | w_timeout;
    end

    // Timeout counter and sticky error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q <= 8'd0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d = (WAIT_CYCLES == 0) ? S_REQ : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 8'd0) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (dev_ack || w_timeout) begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs and the wait counter
    always_comb begin
        wait_cnt_d  = wait_cnt_q;
        dev_req_d   = dev_req_q;
        dev_we_d    = dev_we_q;
        dev_addr_d  = dev_addr_q;
        dev_wdata_d = dev_wdata_q;
        rdy_d       = rdy_q;
        rd_data_d   = rd_data_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    dev_addr_d  = s_addr;
                    dev_we_d    = ~s_rw;
                    dev_wdata_d = s_wr_data;
                    if (WAIT_CYCLES == 0) begin
                        dev_req_d = 1'b1;
                    end else begin
                        wait_cnt_d = C_WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 8'd0) begin
                    dev_req_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 8'd1;
                end
            end
            S_REQ: begin
                // dev_we still holds the access direction here; it is cleared on completion
                if (dev_ack) begin
                    dev_req_d = 1'b0;
                    dev_we_d  = 1'b0;
                    rdy_d     = 1'b0;
                    rd_data_d = dev_we_q ? 32'd0 : dev_rdata;
                end else if (w_timeout) begin
                    dev_req_d = 1'b0;
                    dev_we_d  = 1'b0;
                    rdy_d     = 1'b0;
                    rd_data_d = dev_we_q ? 32'd0 : C_TMO_DATA;
                end
            end
            default: begin
                rdy_d     = 1'b1;
                rd_data_d = 32'd0;
            end
        endcase
    end

    // Output and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q  <= 8'd0;
            dev_req_q   <= 1'b0;
            dev_we_q    <= 1'b0;
            dev_addr_q  <= '0;
            dev_wdata_q <= 32'd0;
            rdy_q       <= 1'b1;
            rd_data_q   <= 32'd0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            dev_req_q   <= dev_req_d;
            dev_we_q    <= dev_we_d;
            dev_addr_q  <= dev_addr_d;
            dev_wdata_q <= dev_wdata_d;
            rdy_q       <= rdy_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign s_rd_data = rd_data_q;
    assign s_rdy_    = rdy_q;
    assign dev_req   = dev_req_q;
    assign dev_we    = dev_we_q;
    assign dev_addr  = dev_addr_q;
    assign dev_wdata = dev_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_slave_if
//  Description : Bench for bus_slave_if. Instance 0 uses WAIT_CYCLES=0,
//                instance 1 uses WAIT_CYCLES=3 and TIMEOUT_CYCLES=16. Each
//                access is checked against a cycle timeline computed from the
//                access parameters (wait states, ack delay, timeout).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_slave_if;

`ifdef BUS_SLAVE_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  cs_n = 2'b11;
    logic [1:0]  as_n = 2'b11;
    logic [1:0]  rw = 2'b11;
    logic [7:0]  addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rd_data [2];
    logic [1:0]  rdy_n;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [7:0]  daddr [2];
    logic [31:0] dwdata [2];
    logic [1:0]  ack = 2'b00;
    logic [31:0] rdata [2];
    logic [1:0]  terr;

    int checks = 0;
    int errors = 0;
    bit te_exp [2];

    always #5 clk = ~clk;

    bus_slave_if #(.ADDR_W(8), .WAIT_CYCLES(0), .TIMEOUT_CYCLES(255)) u_dut0 (
        .clk(clk), .reset(reset), .s_cs_(cs_n[0]), .s_as_(as_n[0]), .s_rw(rw[0]),
        .s_addr(addr[0]), .s_wr_data(wdata[0]), .s_rd_data(rd_data[0]), .s_rdy_(rdy_n[0]),
        .dev_req(req[0]), .dev_we(we[0]), .dev_addr(daddr[0]), .dev_wdata(dwdata[0]),
        .dev_ack(ack[0]), .dev_rdata(rdata[0]), .timeout_err(terr[0])
    );

    bus_slave_if #(.ADDR_W(8), .WAIT_CYCLES(3), .TIMEOUT_CYCLES(16)) u_dut1 (
        .clk(clk), .reset(reset), .s_cs_(cs_n[1]), .s_as_(as_n[1]), .s_rw(rw[1]),
        .s_addr(addr[1]), .s_wr_data(wdata[1]), .s_rd_data(rd_data[1]), .s_rdy_(rdy_n[1]),
        .dev_req(req[1]), .dev_we(we[1]), .dev_addr(daddr[1]), .dev_wdata(dwdata[1]),
        .dev_ack(ack[1]), .dev_rdata(rdata[1]), .timeout_err(terr[1])
    );

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic int tmo_of(input int k);
        return (k == 0) ? 255 : 16;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus access on instance k. ack_dly: cycles dev_req is high before dev_ack
    // (0 = ack in the first REQ cycle). Timeline t counts falling edges after as_.
    task automatic access(input int k, input bit is_rd, input logic [7:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int ack_dly,
                          input bit spurious, input bit extra_as, input int idle);
        int  w;
        int  deff;
        int  tend;
        bit  tmo;
        logic [31:0] exp_rd;
        w    = wait_of(k);
        tmo  = TMO_EN && (ack_dly >= tmo_of(k));
        deff = tmo ? tmo_of(k) - 1 : ack_dly;
        tend = 2 + w + deff;
        exp_rd = !is_rd ? 32'd0 : (tmo ? 32'hDEAD_BEEF : rd);
        @(negedge clk);
        cs_n[k] = 1'b0; as_n[k] = 1'b0; rw[k] = is_rd; addr[k] = a; wdata[k] = wd;
        for (int t = 1; t <= tend + idle; t++) begin
            @(negedge clk);
            chk($sformatf("dut%0d_req_t%0d", k, t), {31'd0, req[k]}, {31'd0, (t >= 1 + w) && (t < tend)});
            chk($sformatf("dut%0d_rdy_t%0d", k, t), {31'd0, rdy_n[k]}, {31'd0, t != tend});
            chk($sformatf("dut%0d_rdata_t%0d", k, t), rd_data[k], (t == tend) ? exp_rd : 32'd0);
            chk($sformatf("dut%0d_addr_t%0d", k, t), {24'd0, daddr[k]}, {24'd0, a});
            chk($sformatf("dut%0d_wdata_t%0d", k, t), dwdata[k], wd);
            if (t < tend) begin
                chk($sformatf("dut%0d_we_t%0d", k, t), {31'd0, we[k]}, {31'd0, !is_rd});
            end
            if (tmo && t == tend) te_exp[k] = 1'b1;
            chk($sformatf("dut%0d_terr_t%0d", k, t), {31'd0, terr[k]}, {31'd0, te_exp[k]});
            if (t == 1) begin
                cs_n[k] = 1'b1; as_n[k] = 1'b1;
            end
            if (extra_as && t == 1 + w) begin
                cs_n[k] = 1'b0; as_n[k] = 1'b0;
            end
            if (extra_as && t == 2 + w) begin
                cs_n[k] = 1'b1; as_n[k] = 1'b1;
            end
            rdata[k] = $urandom;
            ack[k]   = 1'b0;
            if (!tmo && t == 1 + w + ack_dly) begin
                ack[k]   = 1'b1;
                rdata[k] = rd;
            end else if (spurious && t <= w && $urandom_range(0, 1) == 1) begin
                ack[k] = 1'b1;
            end
        end
        ack[k] = 1'b0;
    endtask

    initial begin
        addr[0] = 8'd0; addr[1] = 8'd0; wdata[0] = 32'd0; wdata[1] = 32'd0;
        rdata[0] = 32'd0; rdata[1] = 32'd0;
        te_exp[0] = 1'b0; te_exp[1] = 1'b0;

        // Reset values on both instances
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst%0d_rdy", k), {31'd0, rdy_n[k]}, 32'd1);
            chk($sformatf("rst%0d_rdata", k), rd_data[k], 32'd0);
            chk($sformatf("rst%0d_req", k), {31'd0, req[k]}, 32'd0);
            chk($sformatf("rst%0d_we", k), {31'd0, we[k]}, 32'd0);
            chk($sformatf("rst%0d_addr", k), {24'd0, daddr[k]}, 32'd0);
            chk($sformatf("rst%0d_wdata", k), dwdata[k], 32'd0);
            chk($sformatf("rst%0d_terr", k), {31'd0, terr[k]}, 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);

        // Minimum-latency read
        access(0, 1'b1, 8'h11, 32'h0, 32'h1234_5678, 0, 1'b0, 1'b0, 2);
        // Write with three wait states
        access(1, 1'b0, 8'h3C, 32'hA5A5_0F0F, 32'h7777_7777, 1, 1'b1, 1'b0, 2);

        // as_ without chip select is ignored
        @(negedge clk);
        cs_n[0] = 1'b1; as_n[0] = 1'b0; rw[0] = 1'b1;
        @(negedge clk);
        as_n[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("nocs_req", {31'd0, req[0]}, 32'd0);
            chk("nocs_rdy", {31'd0, rdy_n[0]}, 32'd1);
            @(negedge clk);
        end
        // Second as_ while busy: exactly one completion
        access(0, 1'b1, 8'h42, 32'h0, 32'hCAFE_F00D, 3, 1'b0, 1'b1, 4);

        // Asynchronous reset in REQ aborts the access immediately
        @(negedge clk);
        cs_n[1] = 1'b0; as_n[1] = 1'b0; rw[1] = 1'b1; addr[1] = 8'h5A; wdata[1] = 32'h0;
        @(negedge clk);
        cs_n[1] = 1'b1; as_n[1] = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_rst_req", {31'd0, req[1]}, 32'd1);
        #2 reset = 1'b0;
        te_exp[0] = 1'b0; te_exp[1] = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, req[1]}, 32'd0);
        chk("mid_rst_rdy", {31'd0, rdy_n[1]}, 32'd1);
        chk("mid_rst_addr", {24'd0, daddr[1]}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_rdy", {31'd0, rdy_n[1]}, 32'd1);
            chk("post_rst_req", {31'd0, req[1]}, 32'd0);
        end
        access(0, 1'b1, 8'h01, 32'h0, 32'h1234_5678, 0, 1'b0, 1'b0, 1);

        // Timeout: dev_ack never arrives
        if (TMO_EN) begin
            access(1, 1'b1, 8'h77, 32'h0, 32'h0BAD_0BAD, 1000, 1'b0, 1'b0, 2);
            access(1, 1'b0, 8'h78, 32'h1357_9BDF, 32'h0, 2, 1'b0, 1'b0, 1);
        end

        // Back-to-back reads on each instance
        access(0, 1'b1, 8'h20, 32'h0, 32'h0000_0001, 1, 1'b0, 1'b0, 0);
        access(0, 1'b1, 8'h21, 32'h0, 32'h8000_0000, 0, 1'b0, 1'b0, 1);
        access(1, 1'b1, 8'h30, 32'h0, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 0);
        access(1, 1'b1, 8'h31, 32'h0, 32'h5555_AAAA, 2, 1'b0, 1'b0, 1);

        // Randomised accesses
        for (int n = 0; n < 24; n++) begin
            int k;
            int d;
            k = int'($urandom_range(0, 1));
            d = int'($urandom_range(0, 5));
            if (TMO_EN && k == 1 && $urandom_range(0, 5) == 0) d = 40;
            access(k, 1'($urandom_range(0, 1)), 8'($urandom), $urandom, $urandom, d,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end
        @(negedge clk);
        chk("final_rdy0", {31'd0, rdy_n[0]}, 32'd1);
        chk("final_rdy1", {31'd0, rdy_n[1]}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
